// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : MIPS instruction-fetch stage plus the IF/ID pipeline register.
//            Owns the fetch PC and talks to a variable-latency instruction
//            memory with one outstanding request. Honours decode's stall
//            through a one-entry skid buffer. Applies jump/branch redirects
//            after the single delay slot, and never squashes anything.
// Ports    : clk, rst_n             clock, async active-low reset
//            stall                  decode must hold its current instruction
//            jump_branch/target/reg decode redirect requests (reg > target > branch)
//            jr_pc                  register-jump target from decode
//            imem_req/addr          fetch request to instruction memory
//            imem_ack/rdata         completion and instruction word from memory
//            pc_id/instr_id/valid   IF/ID register contents presented to decode
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        instr_valid
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      r_state,      w_state_nxt;
    logic        r_run;
    logic [31:0] r_fetch_pc,   w_fetch_pc_nxt;
    logic        r_pend,       w_pend_nxt;
    logic [31:0] r_pend_pc,    w_pend_pc_nxt;
    logic [31:0] r_skid_pc,    w_skid_pc_nxt;
    logic [31:0] r_skid_instr, w_skid_instr_nxt;
    logic [31:0] r_pc_id,      w_pc_id_nxt;
    logic [31:0] r_instr_id,   w_instr_id_nxt;
    logic        r_valid,      w_valid_nxt;

    logic        w_req;
    logic        w_ack;
    logic        w_adv;
    logic        w_redirect;
    logic [31:0] w_pc4;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;

    // r_run holds the request low until the first edge after reset release.
    assign w_req      = r_run & (r_state == S_FETCH);
    // A stray ack with no request (e.g. late ack after reset) is ignored.
    assign w_ack      = imem_ack & w_req;
    assign w_adv      = ~stall | ~r_valid;
    assign w_redirect = r_valid & ~stall & (jump_branch | jump_target | jump_reg);
    assign w_pc4      = r_pc_id + 32'd4;

    always_comb begin
        w_target = w_pc4 + {{14{r_instr_id[15]}}, r_instr_id[15:0], 2'b00};
        if (jump_reg) begin
            w_target = jr_pc;
        end else if (jump_target) begin
            w_target = {w_pc4[31:28], r_instr_id[25:0], 2'b00};
        end
    end

    always_comb begin
        if (w_redirect) begin
            w_next_pc = w_target;
        end else if (r_pend) begin
            w_next_pc = r_pend_pc;
        end else begin
            w_next_pc = r_fetch_pc + 32'd4;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_pend_nxt       = r_pend;
        w_pend_pc_nxt    = r_pend_pc;
        w_skid_pc_nxt    = r_skid_pc;
        w_skid_instr_nxt = r_skid_instr;
        w_pc_id_nxt      = r_pc_id;
        w_instr_id_nxt   = r_instr_id;
        w_valid_nxt      = r_valid;
        case (r_state)
            S_FETCH: begin
                if (w_ack) begin
                    w_fetch_pc_nxt = w_next_pc;
                    w_pend_nxt     = 1'b0;
                    if (w_adv) begin
                        w_pc_id_nxt    = r_fetch_pc;
                        w_instr_id_nxt = imem_rdata;
                        w_valid_nxt    = 1'b1;
                    end else begin
                        w_skid_pc_nxt    = r_fetch_pc;
                        w_skid_instr_nxt = imem_rdata;
                        w_state_nxt      = S_HOLD;
                    end
                end else begin
                    // The outstanding request is the delay slot; remember
                    // where to go once it completes.
                    if (w_redirect) begin
                        w_pend_nxt    = 1'b1;
                        w_pend_pc_nxt = w_target;
                    end
                    if (w_adv) begin
                        w_valid_nxt    = 1'b0;
                        w_instr_id_nxt = 32'h0000_0000;
                    end
                end
            end
            S_HOLD: begin
                if (w_adv) begin
                    w_pc_id_nxt    = r_skid_pc;
                    w_instr_id_nxt = r_skid_instr;
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = S_FETCH;
                end
                // The skid entry is the delay slot, so the redirect
                // replaces the already-advanced fetch PC.
                if (w_redirect) begin
                    w_fetch_pc_nxt = w_target;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_run        <= 1'b0;
            r_fetch_pc   <= RESET_PC;
            r_pend       <= 1'b0;
            r_pend_pc    <= 32'h0000_0000;
            r_skid_pc    <= 32'h0000_0000;
            r_skid_instr <= 32'h0000_0000;
            r_pc_id      <= 32'h0000_0000;
            r_instr_id   <= 32'h0000_0000;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_run        <= 1'b1;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_pc_id      <= w_pc_id_nxt;
            r_instr_id   <= w_instr_id_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_fetch_pc;
    assign pc_id       = r_pc_id;
    assign instr_id    = r_instr_id;
    assign instr_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. A per-cycle vector table
//            drives decode/memory controls; expected request and IF/ID
//            contents are queued at drive time and compared after the edge.
//            Hand-written sequences cover reset state and reset mid-request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        jump_branch;
    logic        jump_target;
    logic        jump_reg;
    logic [31:0] jr_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        instr_valid;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_stage #(.RESET_PC(C_RESET_PC)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .jump_branch (jump_branch),
        .jump_target (jump_target),
        .jump_reg    (jump_reg),
        .jr_pc       (jr_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_id       (pc_id),
        .instr_id    (instr_id),
        .instr_valid (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: BEQ at 0x20 (imm 3), J at 0x104 (index 0x50),
    // BEQ at 0x140 (imm -2); everything else is an address-tagged word.
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0020: mem = 32'h1000_0003;
            32'h0000_0104: mem = 32'h0800_0050;
            32'h0000_0140: mem = 32'h1000_FFFE;
            default:       mem = 32'hA500_0000 | a;
        endcase
    endfunction

    assign imem_rdata = mem(imem_addr);

    typedef struct packed {
        logic        st;
        logic        jb;
        logic        jt;
        logic        jr;
        logic [31:0] jrpc;
        logic        ack;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
    } vec_t;

    typedef struct packed {
        logic        evld;
        logic [31:0] epc;
        logic [31:0] einstr;
    } exp_t;

    localparam int C_NVEC = 33;
    vec_t vecs [C_NVEC];
    exp_t sb_q [$];

    function automatic vec_t mk(input logic st, input logic jb, input logic jt,
                                input logic jr, input logic [31:0] jrpc,
                                input logic ack, input logic ereq,
                                input logic [31:0] eaddr, input logic evld,
                                input logic [31:0] epc);
        mk = '{st, jb, jt, jr, jrpc, ack, ereq, eaddr, evld, epc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        //             st jb jt jr jrpc          ack req addr          vld pc
        vecs[0]  = mk(0, 0, 0, 0, 32'h0,       1,  0, 32'h000,      0, 32'h000);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h000,      1, 32'h000);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h004,      1, 32'h004);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,       0,  1, 32'h008,      0, 32'h000);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,       0,  1, 32'h008,      0, 32'h000);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h008,      1, 32'h008);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h00C,      1, 32'h00C);
        vecs[7]  = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h010,      1, 32'h010);
        vecs[8]  = mk(1, 0, 0, 0, 32'h0,       1,  1, 32'h014,      1, 32'h010);
        vecs[9]  = mk(1, 0, 0, 0, 32'h0,       0,  0, 32'h018,      1, 32'h010);
        vecs[10] = mk(0, 0, 0, 0, 32'h0,       0,  0, 32'h018,      1, 32'h014);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h018,      1, 32'h018);
        vecs[12] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h01C,      1, 32'h01C);
        vecs[13] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h020,      1, 32'h020);
        vecs[14] = mk(0, 1, 0, 0, 32'h0,       1,  1, 32'h024,      1, 32'h024);
        vecs[15] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h030,      1, 32'h030);
        vecs[16] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h034,      1, 32'h034);
        vecs[17] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h038,      1, 32'h038);
        vecs[18] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h03C,      1, 32'h03C);
        vecs[19] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h040,      1, 32'h040);
        vecs[20] = mk(0, 0, 1, 1, 32'h100,     0,  1, 32'h044,      0, 32'h000);
        vecs[21] = mk(0, 0, 0, 0, 32'h0,       0,  1, 32'h044,      0, 32'h000);
        vecs[22] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h044,      1, 32'h044);
        vecs[23] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h100,      1, 32'h100);
        vecs[24] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h104,      1, 32'h104);
        vecs[25] = mk(0, 1, 1, 0, 32'h0,       1,  1, 32'h108,      1, 32'h108);
        vecs[26] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h140,      1, 32'h140);
        vecs[27] = mk(1, 0, 0, 0, 32'h0,       1,  1, 32'h144,      1, 32'h140);
        vecs[28] = mk(0, 1, 0, 0, 32'h0,       0,  0, 32'h148,      1, 32'h144);
        vecs[29] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h13C,      1, 32'h13C);
        vecs[30] = mk(1, 0, 1, 0, 32'h0,       0,  1, 32'h140,      1, 32'h13C);
        vecs[31] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h140,      1, 32'h140);
        vecs[32] = mk(0, 0, 0, 0, 32'h0,       1,  1, 32'h144,      1, 32'h144);

        rst_n = 1'b0; stall = 1'b0; jump_branch = 1'b0; jump_target = 1'b0;
        jump_reg = 1'b0; jr_pc = 32'h0; imem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req",   {31'd0, imem_req},    32'd0);
        chk("reset_valid", {31'd0, instr_valid}, 32'd0);
        chk("reset_instr", instr_id,             32'd0);
        chk("reset_pc",    pc_id,                32'd0);

        for (int i = 0; i < C_NVEC; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            stall       = vecs[i].st;
            jump_branch = vecs[i].jb;
            jump_target = vecs[i].jt;
            jump_reg    = vecs[i].jr;
            jr_pc       = vecs[i].jrpc;
            imem_ack    = vecs[i].ack;
            sb_q.push_back('{vecs[i].evld, vecs[i].epc,
                             vecs[i].evld ? mem(vecs[i].epc) : 32'h0});
            #1;
            chk($sformatf("v%0d_req", i),  {31'd0, imem_req}, {31'd0, vecs[i].ereq});
            chk($sformatf("v%0d_addr", i), imem_addr,         vecs[i].eaddr);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL v%0d_scoreboard: queue empty, expected one entry", i);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, e.evld});
                chk($sformatf("v%0d_instr", i), instr_id,             e.einstr);
                if (e.evld) chk($sformatf("v%0d_pc", i), pc_id, e.epc);
            end
        end

        // Reset asserted asynchronously while the request at 0x148 waits.
        @(negedge clk);
        stall = 1'b0; jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("pre_rst_req",  {31'd0, imem_req}, 32'd1);
        chk("pre_rst_addr", imem_addr,         32'h148);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req",   {31'd0, imem_req},    32'd0);
        chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_rst_instr", instr_id,             32'd0);
        chk("async_rst_pc",    pc_id,                32'd0);
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("in_rst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_req",   {31'd0, imem_req},    32'd1);
        chk("post_rst_addr",  imem_addr,            C_RESET_PC);
        chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_id_valid", {31'd0, instr_valid}, 32'd1);
        chk("post_rst_id_pc",    pc_id,                C_RESET_PC);
        chk("post_rst_id_instr", instr_id,             mem(C_RESET_PC));
        chk("post_rst_next",     imem_addr,            C_RESET_PC + 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
